// File: rtl/bus_pkg.sv
// ============================================================
// bus_pkg : shared BUSI command, address and target-state types
// Rev 1.0
// ============================================================
`default_nettype none

package bus_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'd0,
    CMD_READ  = 3'd1,
    CMD_WRITE = 3'd2,
    CMD_RDATA = 3'd3,
    CMD_WACK  = 3'd4,
    CMD_ERR   = 3'd7
  } cmd_t;

  localparam logic [3:0] RESP_TAR = 4'hF;

  localparam logic [3:0][31:0] DEV_BASE = {
    32'hF000_0300, 32'hF000_0200, 32'hF000_0100, 32'hF000_0000
  };

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_RD_FETCH = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RESP     = 3'd4
  } tgt_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_target_port.sv
// ============================================================
// bus_target_port : BUSI device-side responder driving a local register port
// Rev 1.0
// ============================================================
`default_nettype none

module bus_target_port
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEV_BASE[0],
  parameter int unsigned NREGS     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [31:0] addrdatain,
  input  logic [1:0]  lenin,
  input  logic        ackin,
  output logic        reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [31:0] addrdataout,
  output logic [1:0]  lenout,
  output logic [5:0]  reg_idx,
  output logic        reg_wr,
  output logic [31:0] reg_wdata,
  output logic        reg_rd,
  input  logic [31:0] reg_rdata,
  output logic        busy
);

  localparam logic [6:0] C_NREGS = 7'(NREGS);

  tgt_state_t  r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_len;
  logic [1:0]  r_beat;
  logic [5:0]  r_idx;
  logic        r_is_read;

  logic [5:0]  w_idx;
  logic [6:0]  w_range;
  logic        w_err;
  logic [5:0]  w_beat_idx;
  logic [5:0]  w_next_idx;

  // Range is checked one bit wider so an overrunning burst cannot alias back into range.
  assign w_idx      = addrdatain[7:2];
  assign w_range    = {1'b0, w_idx} + {5'b0, lenin};
  assign w_err      = (addrdatain[31:8] != BASE_ADDR[31:8]) ||
                      (w_range >= C_NREGS) ||
                      !((cmdin == CMD_READ) || (cmdin == CMD_WRITE));
  assign w_beat_idx = r_idx + {4'b0, r_beat};
  assign w_next_idx = w_beat_idx + 6'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_is_read   <= 1'b0;
      reqout      <= 1'b0;
      reqtar      <= '0;
      cmdout      <= '0;
      addrdataout <= '0;
      lenout      <= '0;
      reg_idx     <= '0;
      reg_wr      <= 1'b0;
      reg_wdata   <= '0;
      reg_rd      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (selin) begin
            r_addr    <= addrdatain;
            r_len     <= lenin;
            r_idx     <= w_idx;
            r_beat    <= '0;
            r_is_read <= (cmdin == CMD_READ) && !w_err;
            busy      <= 1'b1;
            if (w_err) begin
              r_state     <= ST_RESP;
              reqout      <= 1'b1;
              reqtar      <= RESP_TAR;
              cmdout      <= CMD_ERR;
              lenout      <= '0;
              addrdataout <= addrdatain;
            end else if (cmdin == CMD_WRITE) begin
              r_state <= ST_WDATA;
            end else begin
              r_state <= ST_RD_FETCH;
              reg_rd  <= 1'b1;
              reg_idx <= w_idx;
            end
          end
        end
        ST_WDATA: begin
          if (selin) begin
            reg_wr    <= 1'b1;
            reg_idx   <= w_beat_idx;
            reg_wdata <= addrdatain;
            if (r_beat == r_len) begin
              r_state     <= ST_RESP;
              reqout      <= 1'b1;
              reqtar      <= RESP_TAR;
              cmdout      <= CMD_WACK;
              lenout      <= r_len;
              addrdataout <= r_addr;
            end else begin
              r_beat <= r_beat + 2'd1;
            end
          end
        end
        // reg_rd was pulsed on entry; the bank returns data during RD_WAIT.
        ST_RD_FETCH: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_state     <= ST_RESP;
          reqout      <= 1'b1;
          reqtar      <= RESP_TAR;
          cmdout      <= CMD_RDATA;
          lenout      <= r_len;
          addrdataout <= reg_rdata;
        end
        ST_RESP: begin
          if (ackin) begin
            reqout <= 1'b0;
            reqtar <= '0;
            if (r_is_read && (r_beat != r_len)) begin
              r_beat  <= r_beat + 2'd1;
              r_state <= ST_RD_FETCH;
              reg_rd  <= 1'b1;
              reg_idx <= w_next_idx;
            end else begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          reqout  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_target_port.sv
// ============================================================
// tb_bus_target_port : scoreboard bench for bus_target_port with a 1-cycle register bank
// Rev 1.0
// ============================================================
`default_nettype none

module tb_bus_target_port;
  import bus_pkg::*;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [31:0] data;
    logic [1:0]  len;
  } resp_t;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        selin = 1'b0;
  logic [2:0]  cmdin = '0;
  logic [31:0] addrdatain = '0;
  logic [1:0]  lenin = '0;
  logic        ackin = 1'b0;
  logic        reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [31:0] addrdataout;
  logic [1:0]  lenout;
  logic [5:0]  reg_idx;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int rd_count = 0;
  int strobe_clash = 0;

  resp_t exp_q[$];
  wr_t   exp_wr[$];
  wr_t   obs_wr[$];
  wr_t   mon_w;
  logic [31:0] bank [64];

  always #5 clk = ~clk;

  bus_target_port #(.BASE_ADDR(32'hF000_0000), .NREGS(16)) dut (
    .clk(clk), .reset(reset), .selin(selin), .cmdin(cmdin), .addrdatain(addrdatain),
    .lenin(lenin), .ackin(ackin), .reqout(reqout), .reqtar(reqtar), .cmdout(cmdout),
    .addrdataout(addrdataout), .lenout(lenout), .reg_idx(reg_idx), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (reg_wr) bank[reg_idx] <= reg_wdata;
    if (reg_rd) reg_rdata <= bank[reg_idx];
  end

  always @(negedge clk) begin
    if (reg_wr) begin
      mon_w.idx  = reg_idx;
      mon_w.data = reg_wdata;
      obs_wr.push_back(mon_w);
    end
    if (reg_rd) rd_count++;
    if (reg_wr && reg_rd) strobe_clash++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_addr(input logic [2:0] c, input logic [31:0] a, input logic [1:0] l);
    selin = 1'b1; cmdin = c; addrdatain = a; lenin = l;
    cyc();
    selin = 1'b0; cmdin = '0; addrdatain = '0; lenin = '0;
  endtask

  task automatic send_data(input logic [31:0] d);
    selin = 1'b1; addrdatain = d;
    cyc();
    selin = 1'b0; addrdatain = '0;
  endtask

  task automatic push_resp(input logic [2:0] c, input logic [31:0] d, input logic [1:0] l);
    resp_t r;
    r.cmd = c; r.data = d; r.len = l;
    exp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [5:0] i, input logic [31:0] d);
    wr_t w;
    w.idx = i; w.data = d;
    exp_wr.push_back(w);
  endtask

  // Waits for reqout, holds off ackin for dly cycles watching for changes, then accepts the beat.
  task automatic wait_resp(input int dly, output resp_t got, output int waited,
                           output logic clean, output logic ok);
    waited = 0; ok = 1'b1; clean = 1'b1; got = '0;
    while (reqout !== 1'b1 && waited < 40) begin
      cyc();
      waited++;
    end
    if (reqout !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    got.cmd = cmdout; got.data = addrdataout; got.len = lenout;
    if (reqtar !== RESP_TAR) clean = 1'b0;
    for (int i = 0; i < dly; i++) begin
      cyc();
      if (reqout !== 1'b1 || reqtar !== RESP_TAR || cmdout !== got.cmd ||
          addrdataout !== got.data || lenout !== got.len) clean = 1'b0;
    end
    ackin = 1'b1;
    cyc();
    ackin = 1'b0;
    if (reqout !== 1'b0) clean = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    cyc(); cyc();
    checks++;
    if ({reqout, reqtar, cmdout, addrdataout, lenout, reg_idx, reg_wr, reg_wdata, reg_rd, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got reqout=%b cmd=%h data=%h busy=%b required all zero",
               reqout, cmdout, addrdataout, busy);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_write_single();
    resp_t got, e; int waited; logic clean, ok; wr_t ew, ow;
    send_addr(CMD_WRITE, 32'hF000_0008, 2'd0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ws_busy: got %b required 1", busy); end
    push_wr(6'd2, 32'h1234_5678);
    push_resp(CMD_WACK, 32'hF000_0008, 2'd0);
    send_data(32'h1234_5678);
    wait_resp(1, got, waited, clean, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin errors++; $display("FAIL ws_timeout: got no reqout required reqout=1"); end
    else if (got !== e) begin errors++; $display("FAIL ws_resp: got %h required %h", got, e); end
    checks++;
    if (waited !== 0) begin errors++; $display("FAIL ws_latency: got %0d required 0", waited); end
    checks++;
    if (clean !== 1'b1) begin errors++; $display("FAIL ws_handshake: got %b required 1", clean); end
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL ws_wr_missing: got none required %h", ew); end
      else begin
        ow = obs_wr.pop_front();
        if (ow !== ew) begin errors++; $display("FAIL ws_wr: got %h required %h", ow, ew); end
      end
    end
  endtask

  task automatic test_read_burst();
    resp_t got, e; int waited; logic clean, ok; int r0;
    logic [31:0] vals [4];
    int dly [4];
    vals[0] = 32'hAAAA_0001; vals[1] = 32'hBBBB_0002; vals[2] = 32'hCCCC_0003; vals[3] = 32'hDDDD_0004;
    dly[0] = 0; dly[1] = 2; dly[2] = 0; dly[3] = 5;
    send_addr(CMD_WRITE, 32'hF000_0004, 2'd3);
    for (int i = 0; i < 4; i++) send_data(vals[i]);
    push_resp(CMD_WACK, 32'hF000_0004, 2'd3);
    wait_resp(0, got, waited, clean, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL rb_fill_wack: got %h ok=%b required %h", got, ok, e); end
    obs_wr.delete();
    r0 = rd_count;
    send_addr(CMD_READ, 32'hF000_0004, 2'd3);
    for (int i = 0; i < 4; i++) push_resp(CMD_RDATA, vals[i], 2'd3);
    for (int i = 0; i < 4; i++) begin
      wait_resp(dly[i], got, waited, clean, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok) begin errors++; $display("FAIL rb_timeout beat %0d: got no reqout required reqout=1", i); end
      else if (got !== e) begin errors++; $display("FAIL rb_beat %0d: got %h required %h", i, got, e); end
      checks++;
      if (waited !== 2) begin errors++; $display("FAIL rb_latency beat %0d: got %0d required 2", i, waited); end
      checks++;
      if (clean !== 1'b1) begin errors++; $display("FAIL rb_stable beat %0d: got %b required 1", i, clean); end
    end
    checks++;
    if (rd_count - r0 !== 4) begin errors++; $display("FAIL rb_rd_count: got %0d required 4", rd_count - r0); end
  endtask

  task automatic test_errors();
    resp_t got, e; int waited; logic clean, ok; int r0;
    logic [2:0]  c [3];
    logic [31:0] a [3];
    logic [1:0]  l [3];
    c[0] = CMD_READ; a[0] = 32'hF000_0100; l[0] = 2'd1;
    c[1] = CMD_READ; a[1] = 32'hF000_0038; l[1] = 2'd3;
    c[2] = 3'd5;     a[2] = 32'hF000_0000; l[2] = 2'd2;
    for (int i = 0; i < 3; i++) begin
      r0 = rd_count;
      send_addr(c[i], a[i], l[i]);
      push_resp(CMD_ERR, a[i], 2'd0);
      wait_resp(1, got, waited, clean, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin errors++; $display("FAIL err_resp %0d: got %h ok=%b required %h", i, got, ok, e); end
      checks++;
      if (rd_count !== r0) begin errors++; $display("FAIL err_no_rd %0d: got %0d reads required 0", i, rd_count - r0); end
    end
    // Highest legal index with a single beat is accepted.
    send_addr(CMD_WRITE, 32'hF000_003C, 2'd0);
    send_data(32'h5A5A_5A5A);
    push_resp(CMD_WACK, 32'hF000_003C, 2'd0);
    wait_resp(0, got, waited, clean, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL err_edge_ok: got %h ok=%b required %h", got, ok, e); end
    obs_wr.delete();
  endtask

  task automatic test_write_burst_stalls();
    resp_t got, e; int waited; logic clean, ok; wr_t ew, ow;
    send_addr(CMD_WRITE, 32'hF000_0000, 2'd2);
    push_wr(6'd0, 32'h0000_1110); send_data(32'h0000_1110);
    cyc(); cyc();
    checks++;
    if (reg_wr !== 1'b0 || reqout !== 1'b0) begin
      errors++; $display("FAIL wb_stall: got reg_wr=%b reqout=%b required 0 0", reg_wr, reqout);
    end
    push_wr(6'd1, 32'h0000_2221); send_data(32'h0000_2221);
    cyc();
    push_wr(6'd2, 32'h0000_3332); send_data(32'h0000_3332);
    push_resp(CMD_WACK, 32'hF000_0000, 2'd2);
    wait_resp(1, got, waited, clean, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin errors++; $display("FAIL wb_wack: got %h ok=%b required %h", got, ok, e); end
    while (exp_wr.size() > 0) begin
      ew = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin errors++; $display("FAIL wb_wr_missing: got none required %h", ew); end
      else begin
        ow = obs_wr.pop_front();
        if (ow !== ew) begin errors++; $display("FAIL wb_wr: got %h required %h", ow, ew); end
      end
    end
    checks++;
    if (obs_wr.size() != 0) begin errors++; $display("FAIL wb_extra_wr: got %0d extra required 0", obs_wr.size()); end
  endtask

  task automatic test_reset_mid();
    resp_t got, e; int waited; logic clean, ok;
    send_addr(CMD_READ, 32'hF000_0000, 2'd3);
    push_resp(CMD_RDATA, 32'h0000_1110, 2'd3);
    push_resp(CMD_RDATA, 32'h0000_2221, 2'd3);
    for (int i = 0; i < 2; i++) begin
      wait_resp(0, got, waited, clean, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin errors++; $display("FAIL rm_beat %0d: got %h ok=%b required %h", i, got, ok, e); end
    end
    cyc();
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({reqout, reqtar, cmdout, addrdataout, lenout, reg_idx, reg_wr, reg_wdata, reg_rd, busy} !== '0) begin
      errors++; $display("FAIL rm_async_clear: got reqout=%b reg_rd=%b busy=%b required all zero", reqout, reg_rd, busy);
    end
    obs_wr.delete();
    cyc(); cyc();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (busy !== 1'b0 || reqout !== 1'b0 || obs_wr.size() != 0) begin
      errors++; $display("FAIL rm_idle_after: got busy=%b reqout=%b writes=%0d required 0 0 0", busy, reqout, obs_wr.size());
    end
    send_addr(CMD_READ, 32'hF000_0008, 2'd1);
    push_resp(CMD_RDATA, 32'h0000_3332, 2'd1);
    push_resp(CMD_RDATA, 32'hCCCC_0003, 2'd1);
    for (int i = 0; i < 2; i++) begin
      wait_resp(1, got, waited, clean, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e || waited !== 2) begin
        errors++; $display("FAIL rm_new_read %0d: got %h wait=%0d required %h wait=2", i, got, waited, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    resp_t got, e; int waited; logic clean, ok; int n;
    send_addr(CMD_READ, 32'hF000_0010, 2'd0);
    push_resp(CMD_RDATA, 32'hDDDD_0004, 2'd0);
    n = 0;
    while (reqout !== 1'b1 && n < 40) begin cyc(); n++; end
    got.cmd = cmdout; got.data = addrdataout; got.len = lenout;
    e = exp_q.pop_front();
    checks++;
    if (reqout !== 1'b1 || got !== e) begin
      errors++; $display("FAIL bb_first: got %h reqout=%b required %h", got, reqout, e);
    end
    ackin = 1'b1; selin = 1'b1; cmdin = CMD_READ; addrdatain = 32'hF000_000C; lenin = 2'd0;
    cyc();
    ackin = 1'b0;
    checks++;
    if (busy !== 1'b0 || reqout !== 1'b0) begin
      errors++; $display("FAIL bb_ignored: got busy=%b reqout=%b required 0 0", busy, reqout);
    end
    cyc();
    selin = 1'b0; cmdin = '0; addrdatain = '0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL bb_accepted: got busy=%b required 1", busy); end
    push_resp(CMD_RDATA, 32'hCCCC_0003, 2'd0);
    wait_resp(0, got, waited, clean, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e || waited !== 2) begin
      errors++; $display("FAIL bb_second: got %h wait=%0d required %h wait=2", got, waited, e);
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_burst();
    test_errors();
    test_write_burst_stalls();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (strobe_clash !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d required 0", strobe_clash); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
